fphub_div_arbiter: RTL and testbench

Shares one FPHUB_divider instance between NREQ independent requesters. Each requester has a valid/ready operand channel. The block arbitrates round-robin, sequences the divider's start/finish protocol, and holds the divider operands stable for the whole operation. It returns each result with the requester id on a single valid/ready response channel. A watchdog flags divider operations that never finish.

---
 rtl/fphub_pkg.sv | 40 ++++
 rtl/fphub_rr_arbiter.sv | 41 ++++
 rtl/fphub_div_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fphub_div_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fphub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fphub_pkg
//  Description : Shared types and helpers for the FPHUB divider arbiter and
//                future shared FPHUB units (state encoding, operand width,
//                round-robin index arithmetic).
//  Revision    : 1.0  initial release
// ============================================================================
package fphub_pkg;

    // Default floating-point format (IEEE single precision)
    localparam int FP_M = 23;
    localparam int FP_E = 8;
    localparam int FP_W = FP_M + FP_E + 1;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Operand width for a given mantissa/exponent split (sign + exp + mant)
    function automatic int op_width(input int m, input int e);
        return m + e + 1;
    endfunction

    // (base + offset) mod n, for base < n and offset < n
    function automatic int rr_index(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fphub_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fphub_rr_arbiter
//  Description : Combinational round-robin picker. Searches the request
//                vector upward from ptr (wrapping at NREQ) and returns the
//                first requester found as a one-hot grant and as an index.
//  Revision    : 1.0  initial release
// ============================================================================
module fphub_rr_arbiter
    import fphub_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] cand;

    // First active request at or after ptr, modulo NREQ
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'(rr_index(int'(ptr), k, NREQ));
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fphub_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fphub_div_arbiter
//  Description : Shares one FPHUB divider among NREQ requesters. Round-robin
//                operand acceptance, divider start/finish sequencing with
//                operands held stable, single response channel tagged with
//                the requester id, and a watchdog for divisions that never
//                finish.
//  Revision    : 1.0  initial release
// ============================================================================
module fphub_div_arbiter
    import fphub_pkg::*;
#(
    parameter int M       = FP_M,
    parameter int E       = FP_E,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*(M+E+1)-1:0]  req_x,
    input  logic [NREQ*(M+E+1)-1:0]  req_d,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [M+E:0]             rsp_res,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_timeout,
    output logic                     div_start,
    output logic [M+E:0]             div_x,
    output logic [M+E:0]             div_d,
    input  logic [M+E:0]             div_res,
    input  logic                     div_finish,
    input  logic                     div_computing,
    output logic                     busy
);

    localparam int W  = op_width(M, E);
    // Timer only needs to reach TIMEOUT-1
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  id_q;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [TW-1:0]   timer;
    logic [W-1:0]    op_x;
    logic [W-1:0]    op_d;
    logic [W-1:0]    res_q;
    logic            timeout_q;
    logic            load_op;
    logic            cap_res;
    logic            cap_timeout;

    logic [W-1:0]    x_slice [NREQ];
    logic [W-1:0]    d_slice [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign x_slice[i] = req_x[i*W +: W];
            assign d_slice[i] = req_d[i*W +: W];
        end
    endgenerate

    fphub_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control. A finish seen in ISSUE comes from the
    // divider's combinational special-case path; in WAIT a finish beats a
    // coincident watchdog expiry. RESP also waits for the divider to go idle
    // so an aborted operation drains before the next start.
    always_comb begin
        state_d     = state_q;
        load_op     = 1'b0;
        cap_res     = 1'b0;
        cap_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    load_op = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (div_finish) begin
                    cap_res = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_finish) begin
                    cap_res = 1'b1;
                    state_d = ST_RESP;
                end else if (timer == TIMER_LAST) begin
                    cap_timeout = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready && !div_computing) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand/id capture on accept; operands then stay put until the next accept
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_ptr <= '0;
            id_q   <= '0;
            op_x   <= '0;
            op_d   <= '0;
        end else if (load_op) begin
            op_x   <= x_slice[grant_idx];
            op_d   <= d_slice[grant_idx];
            id_q   <= grant_idx;
            rr_ptr <= IDW'(rr_index(int'(grant_idx), 1, NREQ));
        end
    end

    // Watchdog timer: cleared while issuing, counts every WAIT cycle
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            timer <= '0;
        end else if (state_q == ST_ISSUE) begin
            timer <= '0;
        end else if (state_q == ST_WAIT) begin
            timer <= timer + 1'b1;
        end
    end

    // Response payload: quotient on finish, zero plus abort flag on watchdog
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            res_q     <= '0;
            timeout_q <= 1'b0;
        end else if (cap_res) begin
            res_q     <= div_res;
            timeout_q <= 1'b0;
        end else if (cap_timeout) begin
            res_q     <= '0;
            timeout_q <= 1'b1;
        end
    end

    assign req_ready   = (state_q == ST_IDLE) ? grant : '0;
    assign div_start   = (state_q == ST_ISSUE);
    assign div_x       = op_x;
    assign div_d       = op_d;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_res     = res_q;
    assign rsp_id      = id_q;
    assign rsp_timeout = timeout_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fphub_div_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fphub_div_arbiter
//  Description : Self-checking bench for fphub_div_arbiter with a stub
//                divider of programmable finish delay.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fphub_div_arbiter;

    localparam int M       = 23;
    localparam int E       = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;
    localparam int W       = 32;

    logic                clk = 1'b0;
    logic                rst_l;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_x;
    logic [NREQ*W-1:0]   req_d;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [W-1:0]        rsp_res;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_timeout;
    logic                div_start;
    logic [W-1:0]        div_x;
    logic [W-1:0]        div_d;
    logic [W-1:0]        div_res;
    logic                div_finish;
    logic                div_computing;
    logic                busy;

    always #5 clk = ~clk;

    fphub_div_arbiter #(
        .M(M), .E(E), .NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_d         (req_d),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_res       (rsp_res),
        .rsp_id        (rsp_id),
        .rsp_timeout   (rsp_timeout),
        .div_start     (div_start),
        .div_x         (div_x),
        .div_d         (div_d),
        .div_res       (div_res),
        .div_finish    (div_finish),
        .div_computing (div_computing),
        .busy          (busy)
    );

    // ---------------- stub divider ----------------
    // delay 0: finish combinationally with start; delay N: finish N cycles after start.
    // Result reads the operand bus at finish time, so it also exposes operand drift.
    int   stub_delay;
    logic stub_hang;
    logic stub_active;
    int   stub_cnt;

    assign div_res       = div_x - div_d + 32'h3F80_0000;
    assign div_finish    = !stub_hang && ((div_start && stub_delay == 0) ||
                                          (stub_active && stub_cnt == stub_delay));
    assign div_computing = stub_active;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stub_active <= 1'b0;
            stub_cnt    <= 0;
        end else if (div_start && !div_finish) begin
            stub_active <= 1'b1;
            stub_cnt    <= 1;
        end else if (stub_active) begin
            if (div_finish || (!stub_hang && stub_cnt >= stub_delay)) stub_active <= 1'b0;
            else stub_cnt <= stub_cnt + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;
    int start_cnt = 0;
    int hold_err  = 0;
    int ready_err = 0;
    logic [W-1:0] hx, hd;
    logic hold_armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand bus must not move between start and the end of the operation
    always @(negedge clk) begin
        if (!rst_l || !busy) begin
            hold_armed <= 1'b0;
        end else if (div_start) begin
            hx         <= div_x;
            hd         <= div_d;
            hold_armed <= 1'b1;
            start_cnt  <= start_cnt + 1;
        end else if (hold_armed && (div_x !== hx || div_d !== hd)) begin
            hold_err <= hold_err + 1;
        end
    end

    // req_ready: at most one bit, only to a valid requester, never while busy
    always @(negedge clk) begin
        if (rst_l && (($countones(req_ready) > 1) || ((req_ready & ~req_valid) != '0) ||
                      (busy && req_ready != '0)))
            ready_err <= ready_err + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int model_ptr = 0;
    logic [W-1:0] vx [NREQ];
    logic [W-1:0] vd [NREQ];

    // Round-robin: first valid requester looking upward from the pointer
    function automatic int model_grant(input logic [NREQ-1:0] mask);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (model_ptr + k) % NREQ;
            if (mask[j[IDW-1:0]]) return j;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] model_div(input logic [W-1:0] x, input logic [W-1:0] d);
        return x - d + 32'h3F80_0000;
    endfunction

    // Accept at T, start at T+1, then delay WAIT cycles (or TIMEOUT if it never finishes)
    function automatic int model_lat(input int delay, input bit hang);
        if (hang) return TIMEOUT + 2;
        if (delay == 0) return 2;
        return delay + 2;
    endfunction

    // ---------------- driver tasks ----------------
    int t_acc;
    int base_starts;
    int acc_wait;

    task automatic present(input logic [NREQ-1:0] mask);
        @(negedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = vx[i];
            req_d[i*W +: W] = vd[i];
        end
        req_valid = mask;
        #1;
    endtask

    task automatic accept(input int exp_g, input bit keep);
        acc_wait = 0;
        while (req_ready == '0 && acc_wait < 300) begin
            @(negedge clk);
            #1;
            acc_wait++;
        end
        check("grant", 32'(req_ready), 32'd1 << exp_g);
        t_acc       = cyc;
        base_starts = start_cnt;
        model_ptr   = (exp_g + 1) % NREQ;
        @(posedge clk);
        #1;
        if (!keep) req_valid = '0;
        @(negedge clk);
        check("start_t1", 32'(div_start), 32'd1);
    endtask

    task automatic wait_rsp(output int lat);
        int b;
        b = 0;
        while (!rsp_valid && b < 300) begin
            @(negedge clk);
            b++;
        end
        lat = cyc - t_acc;
    endtask

    task automatic ack(input int rdy_wait);
        logic [W-1:0]   r0;
        logic [IDW-1:0] i0;
        logic           t0;
        int             bad;
        int             b;
        r0 = rsp_res; i0 = rsp_id; t0 = rsp_timeout; bad = 0;
        for (int k = 0; k < rdy_wait; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_res !== r0 || rsp_id !== i0 ||
                rsp_timeout !== t0 || req_ready !== '0) bad++;
        end
        if (rdy_wait > 0) check("rsp_stable", bad, 0);
        rsp_ready = 1'b1;
        b = 0;
        do begin
            @(posedge clk);
            #1;
            b++;
        end while (rsp_valid && b < 200);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
    endtask

    task automatic do_op(input logic [NREQ-1:0] mask, input int g, input int delay,
                         input int rdy_wait, input logic [W-1:0] exp_res, input int exp_lat);
        int lat;
        stub_delay = delay;
        stub_hang  = 1'b0;
        present(mask);
        accept(g, 1'b0);
        wait_rsp(lat);
        check("latency", lat, exp_lat);
        check("rsp_res", rsp_res, exp_res);
        check("rsp_id", 32'(rsp_id), g);
        check("rsp_timeout", 32'(rsp_timeout), 32'd0);
        ack(rdy_wait);
        check("start_once", start_cnt - base_starts, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_div_start"}, 32'(div_start), 0);
        check({tag, "_div_x"}, div_x, 0);
        check({tag, "_div_d"}, div_d, 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_res"}, rsp_res, 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] x;
        logic [W-1:0] d;
        int           delay;
        logic [W-1:0] res;
        int           lat;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int lat;
        int g;
        int bad;
        logic [NREQ-1:0] mask;

        tbl[0] = '{0, 32'h4040_0000, 32'h4000_0000, 10, 32'h3FC0_0000, 12};
        tbl[1] = '{1, 32'h4000_0000, 32'h3F80_0000,  0, 32'h4000_0000,  2};
        tbl[2] = '{2, 32'h4080_0000, 32'h3F00_0000,  1, 32'h4100_0000,  3};
        tbl[3] = '{3, 32'h4120_0000, 32'h40A0_0000,  3, 32'h4000_0000,  5};

        rst_l      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_d      = '0;
        rsp_ready  = 1'b0;
        stub_delay = 1;
        stub_hang  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin vx[i] = '0; vd[i] = '0; end

        #1;
        check_reset("reset");
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        model_ptr = 0;

        // Directed table: one requester at a time, fixed expected results
        for (int v = 0; v < 4; v++) begin
            vx[tbl[v].id] = tbl[v].x;
            vd[tbl[v].id] = tbl[v].d;
            do_op(4'b1 << tbl[v].id, tbl[v].id, tbl[v].delay, 0, tbl[v].res, tbl[v].lat);
        end

        // All requesters valid continuously, response always accepted
        for (int i = 0; i < NREQ; i++) begin
            vx[i] = 32'h4000_0000 + (i << 20);
            vd[i] = 32'h3F80_0000 + (i << 16);
        end
        stub_delay = 2;
        rsp_ready  = 1'b1;
        present(4'hF);
        for (int n = 0; n < 5; n++) begin
            g = model_grant(4'hF);
            accept(g, 1'b1);
            wait_rsp(lat);
            check("rr_rsp_id", 32'(rsp_id), g);
            check("rr_rsp_res", rsp_res, model_div(vx[g], vd[g]));
            if (n == 4) req_valid = '0;
            if (n < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Divider never finishes: watchdog abort, then drain before leaving RESP
        vx[1] = 32'h4100_0000;
        vd[1] = 32'h4000_0000;
        stub_delay = 5;
        stub_hang  = 1'b1;
        g = model_grant(4'b0010);
        present(4'b0010);
        accept(g, 1'b0);
        wait_rsp(lat);
        check("to_latency", lat, model_lat(0, 1'b1));
        check("to_flag", 32'(rsp_timeout), 1);
        check("to_res", rsp_res, 0);
        check("to_id", 32'(rsp_id), g);
        rsp_ready = 1'b1;
        bad = 0;
        while (cyc - t_acc < 80) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1) bad++;
        end
        check("to_hold_resp", bad, 0);
        stub_hang = 1'b0;
        bad = 0;
        while (rsp_valid && bad < 10) begin
            @(negedge clk);
            bad++;
        end
        check("to_drain", 32'(rsp_valid), 0);
        rsp_ready = 1'b0;

        // Back-pressured response while another requester waits
        vx[1] = 32'h4200_0000; vd[1] = 32'h4080_0000;
        vx[2] = 32'h4300_0000; vd[2] = 32'h4000_0000;
        stub_delay = 3;
        g = model_grant(4'b0010);
        present(4'b0010);
        accept(g, 1'b0);
        req_valid[2] = 1'b1;
        wait_rsp(lat);
        check("bp_res", rsp_res, model_div(vx[1], vd[1]));
        ack(20);
        g = model_grant(4'b0100);
        accept(g, 1'b0);
        check("bp_grant_next", acc_wait, 0);
        wait_rsp(lat);
        check("bp2_id", 32'(rsp_id), 2);
        check("bp2_res", rsp_res, model_div(vx[2], vd[2]));
        ack(0);

        // Asynchronous reset during WAIT
        vx[0] = 32'h4400_0000; vd[0] = 32'h4100_0000;
        stub_delay = 20;
        g = model_grant(4'b0001);
        present(4'b0001);
        accept(g, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(negedge clk);
        #2;
        rst_l = 1'b1;
        model_ptr = 0;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("no_rsp_after_reset", bad, 0);
        vx[1] = 32'h4150_0000; vd[1] = 32'h3FC0_0000;
        vx[2] = 32'h4000_0000; vd[2] = 32'h4000_0000;
        g = model_grant(4'b0110);
        do_op(4'b0110, g, 4, 1, model_div(vx[g], vd[g]), model_lat(4, 1'b0));

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            int dly;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                vx[i] = $urandom;
                vd[i] = $urandom;
            end
            dly = $urandom_range(0, 8);
            g = model_grant(mask);
            do_op(mask, g, dly, $urandom_range(0, 3), model_div(vx[g], vd[g]), model_lat(dly, 1'b0));
        end

        repeat (2) @(negedge clk);
        check("operand_hold", hold_err, 0);
        check("ready_rules", ready_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
